if_bus_master: RTL



---
 rtl/if_bus_master.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/if_bus_master.sv
// ============================================================================
// Module   : if_bus_master
// Brief    : Instruction-fetch bus initiator (req / grant / strobe / ready).
//            Optional macro FETCH_BUFFER_EN adds a held-result STALL state.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module if_bus_master (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_en,
   input  logic [29:0] addr,
   input  logic        stall,
   input  logic        flush,
   output logic [31:0] rd_data,
   output logic        busy,
   output logic        bus_req,
   input  logic        bus_grnt,
   output logic [29:0] bus_addr,
   output logic        bus_as,
   output logic        bus_rw,
   input  logic [31:0] bus_rd_data,
   input  logic        bus_rdy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ    = 2'd1,
      S_ACCESS = 2'd2,
      S_STALL  = 2'd3
   } state_t;

   localparam logic [31:0] C_NOP = 32'h0000_0000;

   state_t      r_state;
   logic        r_bus_req;
   logic [29:0] r_bus_addr;
   logic        r_flush_pend;
   logic [31:0] w_rd_data;
   logic        w_busy;

`ifdef FETCH_BUFFER_EN
   logic [31:0] r_rd_buf;
`else
   logic        w_unused_stall;
   assign w_unused_stall = stall;
`endif

   assign bus_req  = r_bus_req;
   assign bus_addr = r_bus_addr;
   assign bus_rw   = 1'b1;
   // Strobe marks the grant cycle itself; a same-cycle flush suppresses it.
   assign bus_as   = (r_state == S_REQ) && bus_grnt && !flush;
   assign rd_data  = w_rd_data;
   assign busy     = w_busy;

   always_comb begin
      w_busy    = 1'b0;
      w_rd_data = C_NOP;
      case (r_state)
         S_IDLE: begin
            w_busy = req_en && !flush;
         end
         S_REQ: begin
            w_busy = 1'b1;
         end
         S_ACCESS: begin
            w_busy = !bus_rdy;
            if (bus_rdy && !(r_flush_pend || flush))
               w_rd_data = bus_rd_data;
         end
`ifdef FETCH_BUFFER_EN
         S_STALL: begin
            w_rd_data = r_rd_buf;
         end
`endif
         default: begin
            w_busy    = 1'b0;
            w_rd_data = C_NOP;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_bus_req    <= 1'b0;
         r_bus_addr   <= 30'h0;
         r_flush_pend <= 1'b0;
`ifdef FETCH_BUFFER_EN
         r_rd_buf     <= C_NOP;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_en && !flush) begin
                  r_bus_addr <= addr;
                  r_bus_req  <= 1'b1;
                  r_state    <= S_REQ;
               end
            end
            S_REQ: begin
               if (flush) begin
                  r_bus_req <= 1'b0;
                  r_state   <= S_IDLE;
               end else if (bus_grnt) begin
                  r_state   <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               // The bus cycle always runs to completion; flush only masks data.
               if (bus_rdy) begin
                  r_bus_req    <= 1'b0;
                  r_flush_pend <= 1'b0;
`ifdef FETCH_BUFFER_EN
                  // Hold what the pipeline saw, so a flushed word stays NOP.
                  r_rd_buf     <= w_rd_data;
                  r_state      <= stall ? S_STALL : S_IDLE;
`else
                  r_state      <= S_IDLE;
`endif
               end else if (flush) begin
                  r_flush_pend <= 1'b1;
               end
            end
`ifdef FETCH_BUFFER_EN
            S_STALL: begin
               if (flush) begin
                  r_rd_buf <= C_NOP;
                  r_state  <= S_IDLE;
               end else if (!stall) begin
                  r_state  <= S_IDLE;
               end
            end
`endif
            default: begin
               r_bus_req <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
